// File: rtl/psec6_counter_readout.sv
// ---------------------------------------------------------------------------
// psec6_counter_readout
//
// Readout stage that sits behind the SPI register/address decode. When a read
// of a channel address is requested, it waits for the channel counters to be
// frozen, captures that channel's counter word once, and shifts it out
// MSB-first on poci_cnt. An optional even-parity bit follows the word. The
// frame ends with a one-cycle done pulse. If cs rises, the frame aborts
// cleanly with no done pulse.
//
// Ports
//   spi_clk     in   sole clock, rising edge
//   rst         in   synchronous, active-high reset
//   cs          in   SPI chip select, active-low (1 = frame ended/aborted)
//   rd_start    in   one-cycle pulse: address phase of a read finished
//   rd_addr     in   SPI address, sampled only together with rd_start
//   cnt_stable  in   channel counters frozen and valid
//   ch_data     in   packed counter words, channel k at [k*CNT_W +: CNT_W]
//   poci_cnt    out  serial data out, registered, 0 outside SHIFT
//   busy        out  1 while in WAIT or SHIFT
//   done        out  one-cycle pulse after the last bit (parity included)
//   err_addr    out  sticky: a read addressed something outside the channels
//   err_timeout out  sticky: cnt_stable did not arrive within WAIT_MAX cycles
//
// Handshake: rd_start is a request without back-pressure. It is accepted
// only in IDLE with cs low. While busy is high or done is pulsing, further
// rd_start pulses are dropped. done marks completion for exactly one cycle.
// ---------------------------------------------------------------------------
module psec6_counter_readout #(
    parameter int         NUM_CH    = 8,
    parameter int         CNT_W     = 16,
    parameter logic [6:0] CH_BASE   = 7'd16,
    parameter int         WAIT_MAX  = 255,
    parameter int         PARITY_EN = 1
) (
    input  logic                    spi_clk,
    input  logic                    rst,
    input  logic                    cs,
    input  logic                    rd_start,
    input  logic [6:0]              rd_addr,
    input  logic                    cnt_stable,
    input  logic [NUM_CH*CNT_W-1:0] ch_data,
    output logic                    poci_cnt,
    output logic                    busy,
    output logic                    done,
    output logic                    err_addr,
    output logic                    err_timeout
);

    // Number of SHIFT cycles: the word plus the optional parity bit.
    localparam int SHIFT_LEN = CNT_W + ((PARITY_EN != 0) ? 1 : 0);
    // The shift register always carries one slot below the word for parity.
    // With parity disabled, that slot is loaded with 0 and never reaches the
    // output before DONE.
    localparam int SR_W   = CNT_W + 1;
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam int BIT_W  = $clog2(SHIFT_LEN + 1);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SHIFT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q,       state_d;
    logic [SR_W-1:0]   sr_q,          sr_d;
    logic [BIT_W-1:0]  bit_cnt_q,     bit_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
    logic [SEL_W-1:0]  sel_q,         sel_d;
    logic              err_addr_q,    err_addr_d;
    logic              err_timeout_q, err_timeout_d;
    logic              poci_cnt_q,    poci_cnt_d;
    logic              busy_q,        busy_d;
    logic              done_q,        done_d;

    logic              addr_in_range;
    logic [CNT_W-1:0]  word_sel;
    logic              word_par;

    // Compare with 9 bits so CH_BASE + NUM_CH cannot wrap.
    always_comb begin
        addr_in_range = ({2'b00, rd_addr} >= {2'b00, CH_BASE}) &&
                        ({2'b00, rd_addr} <  ({2'b00, CH_BASE} + 9'(NUM_CH)));
    end

    // Channel select mux on the latched channel index.
    always_comb begin
        word_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_q == SEL_W'(k)) begin
                word_sel = ch_data[k*CNT_W +: CNT_W];
            end
        end
        word_par = (PARITY_EN != 0) ? ^word_sel : 1'b0;
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        sel_d         = sel_q;
        err_addr_d    = err_addr_q;
        err_timeout_d = err_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (rd_start && !cs) begin
                    sel_d      = SEL_W'(rd_addr - CH_BASE);
                    wait_cnt_d = '0;
                    bit_cnt_d  = '0;
                    if (addr_in_range) begin
                        state_d = ST_WAIT;
                    end else begin
                        // Unknown address: still complete a frame, all zeros.
                        err_addr_d = 1'b1;
                        sr_d       = '0;
                        state_d    = ST_SHIFT;
                    end
                end
            end

            ST_WAIT: begin
                if (cs) begin
                    state_d = ST_IDLE;
                end else if (cnt_stable) begin
                    // The word is captured exactly once. Later ch_data changes are ignored.
                    sr_d      = {word_sel, word_par};
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_timeout_d = 1'b1;
                    sr_d          = '0;
                    bit_cnt_d     = '0;
                    state_d       = ST_SHIFT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            ST_SHIFT: begin
                if (cs) begin
                    sr_d    = '0;
                    state_d = ST_IDLE;
                end else begin
                    sr_d = {sr_q[SR_W-2:0], 1'b0};
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so that, once registered,
        // they line up with state_q. This gives no input-to-output path.
        poci_cnt_d = (state_d == ST_SHIFT) ? sr_d[SR_W-1] : 1'b0;
        busy_d     = (state_d == ST_WAIT) || (state_d == ST_SHIFT);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge spi_clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            sel_q         <= '0;
            err_addr_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            poci_cnt_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            sel_q         <= sel_d;
            err_addr_q    <= err_addr_d;
            err_timeout_q <= err_timeout_d;
            poci_cnt_q    <= poci_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign poci_cnt    = poci_cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_addr    = err_addr_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_psec6_counter_readout.sv
// ---------------------------------------------------------------------------
// tb_psec6_counter_readout
//
// Directed and randomized reads checked against a frame-level reference
// model. For each read, the model builds the full expected output sequence
// ({busy, done, poci_cnt} per cycle) from the read rules: the wait length,
// the word bits MSB-first, the parity bit, the done cycle and the idle cycle.
// It also tracks the sticky error flags.
// ---------------------------------------------------------------------------
module tb_psec6_counter_readout;

    localparam int NUM_CH    = 8;
    localparam int CNT_W     = 16;
    localparam int CH_BASE_I = 16;
    localparam int WAIT_MAX  = 255;
    localparam int PARITY_EN = 1;
    localparam int L         = CNT_W + PARITY_EN;

    // ---------------- clock / reset ----------------
    logic                    spi_clk;
    logic                    rst;
    logic                    cs;
    logic                    rd_start;
    logic [6:0]              rd_addr;
    logic                    cnt_stable;
    logic [NUM_CH*CNT_W-1:0] ch_data;
    logic                    poci_cnt;
    logic                    busy;
    logic                    done;
    logic                    err_addr;
    logic                    err_timeout;

    initial spi_clk = 1'b0;
    always #5 spi_clk = ~spi_clk;

    psec6_counter_readout #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .CH_BASE   (7'(CH_BASE_I)),
        .WAIT_MAX  (WAIT_MAX),
        .PARITY_EN (PARITY_EN)
    ) dut (
        .spi_clk     (spi_clk),
        .rst         (rst),
        .cs          (cs),
        .rd_start    (rd_start),
        .rd_addr     (rd_addr),
        .cnt_stable  (cnt_stable),
        .ch_data     (ch_data),
        .poci_cnt    (poci_cnt),
        .busy        (busy),
        .done        (done),
        .err_addr    (err_addr),
        .err_timeout (err_timeout)
    );

    // ---------------- model state / scoreboard ----------------
    logic [CNT_W-1:0] ch_word [NUM_CH];
    logic             err_addr_m;
    logic             err_to_m;
    int               tests;
    int               fails;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge spi_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_CH*CNT_W-1:0] pack_words();
        logic [NUM_CH*CNT_W-1:0] p;
        for (int k = 0; k < NUM_CH; k++) p[k*CNT_W +: CNT_W] = ch_word[k];
        return p;
    endfunction

    task automatic randomize_words();
        for (int k = 0; k < NUM_CH; k++) ch_word[k] = CNT_W'($urandom);
        ch_data = pack_words();
    endtask

    // ---------------- driver + reference model ----------------
    // d       : number of sampled cnt_stable=0 cycles in WAIT before it is seen high
    // abort_e : edge index (0 = rd_start edge) at which cs is raised, -1 for none
    // poke_e  : edge index at which a stray rd_start is pulsed, -1 for none
    task automatic run_read(input string tag, input logic [6:0] addr, input int d,
                            input int abort_e, input int poke_e);
        logic [2:0]       exp_q[$];
        logic             in_rng;
        logic             tmo;
        logic             par;
        logic             ea;
        logic             et_final;
        logic             et;
        logic [CNT_W-1:0] word;
        int               a;
        int               n;
        int               ab;
        int               pk;

        a      = int'(addr);
        in_rng = (a >= CH_BASE_I) && (a < CH_BASE_I + NUM_CH);
        tmo    = in_rng && (d >= WAIT_MAX);
        n      = !in_rng ? 0 : ((d + 1 < WAIT_MAX) ? d + 1 : WAIT_MAX);
        word   = (in_rng && !tmo) ? ch_word[a - CH_BASE_I] : '0;
        par    = ^word;

        ab = abort_e;
        if (ab > n + L) ab = n + L;
        pk = poke_e;
        if (pk > n + L) pk = n + L;
        if (ab >= 0 && pk >= ab) pk = -1;

        for (int i = 0; i < n; i++) exp_q.push_back(3'b100);
        for (int k = 0; k < CNT_W; k++) exp_q.push_back({2'b10, word[CNT_W-1-k]});
        if (PARITY_EN != 0) exp_q.push_back({2'b10, par});
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b000);
        if (ab >= 0) begin
            for (int e = ab; e < exp_q.size(); e++) exp_q[e] = 3'b000;
            while (exp_q.size() > ab + 2) void'(exp_q.pop_back());
        end

        ea       = err_addr_m | !in_rng;
        et_final = err_to_m | (tmo && !(ab >= 0 && ab <= WAIT_MAX));

        for (int e = 0; e < exp_q.size(); e++) begin
            rd_start   = (e == 0) || (e == pk);
            rd_addr    = (e == 0) ? addr : 7'($urandom_range(0, 127));
            cnt_stable = (e == 0) ? (d == 0) : ((e - 1) >= d);
            cs         = (ab >= 0) && (e >= ab);
            if (e > n) begin
                for (int k = 0; k < NUM_CH; k++) ch_data[k*CNT_W +: CNT_W] = CNT_W'($urandom);
            end
            step();
            et = (e >= WAIT_MAX) ? et_final : err_to_m;
            check($sformatf("%s out[%0d]", tag, e), {29'd0, busy, done, poci_cnt}, {29'd0, exp_q[e]});
            check($sformatf("%s err_addr[%0d]", tag, e), {31'd0, err_addr}, {31'd0, ea});
            check($sformatf("%s err_timeout[%0d]", tag, e), {31'd0, err_timeout}, {31'd0, et});
        end

        rd_start   = 1'b0;
        cs         = 1'b0;
        cnt_stable = 1'b0;
        err_addr_m = ea;
        err_to_m   = et_final;
        ch_data    = pack_words();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        tests      = 0;
        fails      = 0;
        err_addr_m = 1'b0;
        err_to_m   = 1'b0;
        rst        = 1'b1;
        cs         = 1'b1;
        rd_start   = 1'b0;
        rd_addr    = '0;
        cnt_stable = 1'b0;
        randomize_words();

        step();
        step();
        check("reset outputs", {27'd0, poci_cnt, busy, done, err_addr, err_timeout}, 32'd0);
        rst = 1'b0;
        cs  = 1'b0;
        step();
        check("idle after reset", {27'd0, poci_cnt, busy, done, err_addr, err_timeout}, 32'd0);

        // Channel 0, counters already stable.
        ch_word[0] = 16'hA5C3;
        ch_data    = pack_words();
        run_read("t1_ch0", 7'd16, 0, -1, -1);

        // Channel 7, stable rises ten cycles after rd_start.
        ch_word[7] = 16'h8001;
        ch_data    = pack_words();
        run_read("t2_ch7", 7'd23, 9, -1, -1);

        // Out-of-range address.
        run_read("t3_oor", 7'd5, 0, -1, -1);
        // Just above the last channel.
        run_read("t3_oor_hi", 7'd24, 0, -1, -1);
        // Just below channel 0.
        run_read("t3_oor_lo", 7'd15, 0, -1, -1);

        // Abort at bit 6 of the shift, then a clean read.
        randomize_words();
        run_read("t5_abort", 7'd19, 2, 9, -1);
        run_read("t5_after", 7'd21, 1, -1, -1);

        // cnt_stable arrives on the last allowed WAIT cycle: data, no timeout.
        randomize_words();
        run_read("edge_lastwait", 7'd17, WAIT_MAX - 1, -1, -1);
        // Never stable: timeout.
        run_read("t4_timeout", 7'd18, 300, -1, -1);

        // rd_start with cs high is ignored.
        cs       = 1'b1;
        rd_start = 1'b1;
        rd_addr  = 7'd20;
        step();
        rd_start = 1'b0;
        cs       = 1'b0;
        step();
        check("cs_high ignored", {29'd0, busy, done, poci_cnt}, 32'd0);

        // Randomized reads with occasional aborts and stray rd_start pulses.
        for (int r = 0; r < 30; r++) begin
            randomize_words();
            run_read($sformatf("rnd%0d", r), 7'($urandom_range(12, 27)), $urandom_range(0, 12),
                     ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 30)) : -1,
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : -1);
        end

        // Reset mid-WAIT, with a stray rd_start pulsed while busy.
        rd_start   = 1'b1;
        rd_addr    = 7'd18;
        cnt_stable = 1'b0;
        step();
        rd_start = 1'b0;
        check("t6 busy", {31'd0, busy}, 32'd1);
        step();
        rd_start = 1'b1;
        rd_addr  = 7'd3;
        step();
        rd_start = 1'b0;
        check("t6 poke busy", {29'd0, busy, done, poci_cnt}, 32'd4);
        check("t6 poke err_addr", {31'd0, err_addr}, {31'd0, err_addr_m});
        rst = 1'b1;
        step();
        check("t6 reset outputs", {27'd0, poci_cnt, busy, done, err_addr, err_timeout}, 32'd0);
        rst        = 1'b0;
        err_addr_m = 1'b0;
        err_to_m   = 1'b0;
        step();
        check("t6 idle", {27'd0, poci_cnt, busy, done, err_addr, err_timeout}, 32'd0);
        randomize_words();
        run_read("t6_after", 7'd20, 3, -1, 4);
        run_read("t6_poke_shift", 7'd22, 0, -1, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
